// File: rtl/spram_pkg.sv
// spram_pkg: shared state type, read-during-write constants and lane helpers for spram_be.
// With SPRAM_BE_PARITY_EN defined a lane is 9 bits: {even parity, data byte}.
package spram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

`ifdef SPRAM_BE_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif

  typedef logic [LANE_W-1:0] lane_t;

  function automatic lane_t byte_merge(input lane_t old_l, input lane_t new_l, input logic be);
    return be ? new_l : old_l;
  endfunction

  function automatic logic byte_parity(input logic [7:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/spram_be_core.sv
// spram_be_core: byte-lane RAM array with a registered read port and selectable
// read-during-write ordering. No reset; the read register holds when re is low.
module spram_be_core
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int NB         = 2,
  parameter int RDW_MODE   = RDW_READ_FIRST
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [NB-1:0]         be,
  input  lane_t [NB-1:0]        wdata,
  input  logic                  re,
  output lane_t [NB-1:0]        rdata
);

  localparam int  DEPTH = 1 << ADDR_WIDTH;
  localparam bit  FWD   = (RDW_MODE == RDW_WRITE_FIRST);

  lane_t [NB-1:0] mem [DEPTH];

  // Stage 0 -> 1: array write and registered read
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) mem[addr][i] <= wdata[i];
      if (re) rdata[i] <= byte_merge(mem[addr][i], wdata[i], FWD && we && be[i]);
    end
  end

endmodule

// File: rtl/spram_be.sv
// spram_be: byte-enable single-port RAM with post-reset zero-fill, 1- or 2-cycle read
// latency, held dout and a valid strobe. Define SPRAM_BE_PARITY_EN for per-lane parity/perr.
module spram_be
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int READ_LAT       = 1,
  parameter int RDW_MODE       = RDW_READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    arstn,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    we,
  input  logic                    re,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    valid,
`ifdef SPRAM_BE_PARITY_EN
  output logic                    perr,
`endif
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic                    c_we;
  logic                    c_re;
  logic [NB-1:0]           c_be;
  lane_t [NB-1:0]          c_wdata;
  lane_t [NB-1:0]          q_core;
  lane_t [NB-1:0]          q_out;
  logic                    vld_p1;

  // Clear sequencer: one zero word per cycle, leaves after the last address
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt <= '0;
      if (CLEAR_ON_RESET != 0) state <= ST_CLEAR;
      else                     state <= ST_IDLE;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) state <= ST_IDLE;
    end
  end

  assign busy = (state == ST_CLEAR);

  always_comb begin
    c_addr = busy ? cnt : addr;
    c_we   = busy | we;
    c_re   = re & ~busy;
    c_be   = busy ? '1 : be;
    for (int i = 0; i < NB; i++) begin
      c_wdata[i] = '0;
      if (!busy) begin
        c_wdata[i][7:0] = din[8*i +: 8];
`ifdef SPRAM_BE_PARITY_EN
        c_wdata[i][8]   = byte_parity(din[8*i +: 8]);
`endif
      end
    end
  end

  spram_be_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NB         (NB),
    .RDW_MODE   (RDW_MODE)
  ) u_core (
    .clk   (clk),
    .addr  (c_addr),
    .we    (c_we),
    .be    (c_be),
    .wdata (c_wdata),
    .re    (c_re),
    .rdata (q_core)
  );

  // Stage 1: read strobe aligned with the core read register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) vld_p1 <= 1'b0;
    else        vld_p1 <= c_re;
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic           vld_p2;
      lane_t [NB-1:0] q_p2;
      // Stage 2: extra output register, loads only on a completed read
      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
          vld_p2 <= 1'b0;
          q_p2   <= '0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) q_p2 <= q_core;
        end
      end
      assign q_out = q_p2;
      assign valid = vld_p2;
    end else begin : g_lat1
      // The core register has no reset, so mask it until the first read lands
      logic rd_seen_p1;
      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)    rd_seen_p1 <= 1'b0;
        else if (c_re) rd_seen_p1 <= 1'b1;
      end
      assign q_out = rd_seen_p1 ? q_core : '0;
      assign valid = vld_p1;
    end
  endgenerate

  always_comb begin
    dout = '0;
    for (int i = 0; i < NB; i++) dout[8*i +: 8] = q_out[i][7:0];
  end

`ifdef SPRAM_BE_PARITY_EN
  logic par_bad;
  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < NB; i++) par_bad = par_bad | (byte_parity(q_out[i][7:0]) != q_out[i][8]);
  end
  assign perr = valid & par_bad;
`endif

endmodule

// File: tb/tb_spram_be.sv
// tb_spram_be: randomized bench for spram_be against an array-level reference model.
// Two instances share stimulus: read-first/latency 1 (u_a) and write-first/latency 2 (u_b).
`timescale 1ns/1ps
module tb_spram_be;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          arstn;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [NB-1:0] be;
  logic          we, re;
  logic [DW-1:0] dout_a, dout_b;
  logic          valid_a, valid_b, busy_a, busy_b;
`ifdef SPRAM_BE_PARITY_EN
  logic          perr_a, perr_b;
`endif

  int total = 0;
  int bad   = 0;
  bit model_on = 1'b1;

  always #5 clk = ~clk;

  spram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .arstn(arstn), .addr(addr), .din(din), .be(be), .we(we), .re(re),
    .dout(dout_a), .valid(valid_a),
`ifdef SPRAM_BE_PARITY_EN
    .perr(perr_a),
`endif
    .busy(busy_a));

  spram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .arstn(arstn), .addr(addr), .din(din), .be(be), .we(we), .re(re),
    .dout(dout_b), .valid(valid_b),
`ifdef SPRAM_BE_PARITY_EN
    .perr(perr_b),
`endif
    .busy(busy_b));

  // ---------------- reference model ----------------
  logic [DW-1:0] mem_m [DEPTH];
  int            clear_left = DEPTH;
  logic          line_v [2][2];
  logic [DW-1:0] line_w [2][2];
  logic          exp_valid [2];
  logic [DW-1:0] exp_dout [2];
  logic          rd_v_m;
  logic [DW-1:0] rd_old_m, rd_new_m;

  initial begin
    for (int d = 0; d < 2; d++) begin
      exp_valid[d] = 1'b0;
      exp_dout[d]  = '0;
      line_v[d][0] = 1'b0;
      line_v[d][1] = 1'b0;
    end
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NB-1:0] m);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      clear_left = DEPTH;
      for (int d = 0; d < 2; d++) begin
        exp_valid[d] = 1'b0;
        exp_dout[d]  = '0;
        line_v[d][0] = 1'b0;
        line_v[d][1] = 1'b0;
      end
    end else begin
      rd_v_m   = 1'b0;
      rd_old_m = '0;
      rd_new_m = '0;
      if (clear_left > 0) begin
        mem_m[DEPTH - clear_left] = '0;
        clear_left--;
      end else begin
        rd_old_m = mem_m[addr];
        rd_new_m = we ? merge(rd_old_m, din, be) : rd_old_m;
        rd_v_m   = re;
        if (we) mem_m[addr] = rd_new_m;
      end
      for (int d = 0; d < 2; d++) begin
        line_v[d][1] = line_v[d][0];
        line_w[d][1] = line_w[d][0];
        line_v[d][0] = rd_v_m;
        line_w[d][0] = (d == 1) ? rd_new_m : rd_old_m;
        exp_valid[d] = line_v[d][lat_of(d)-1];
        if (exp_valid[d]) exp_dout[d] = line_w[d][lat_of(d)-1];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      chk("busy_a",  {31'd0, busy_a},  {31'd0, clear_left > 0});
      chk("busy_b",  {31'd0, busy_b},  {31'd0, clear_left > 0});
      chk("valid_a", {31'd0, valid_a}, {31'd0, exp_valid[0]});
      chk("valid_b", {31'd0, valid_b}, {31'd0, exp_valid[1]});
      chk("dout_a",  {16'd0, dout_a},  {16'd0, exp_dout[0]});
      chk("dout_b",  {16'd0, dout_b},  {16'd0, exp_dout[1]});
`ifdef SPRAM_BE_PARITY_EN
      chk("perr_a",  {31'd0, perr_a},  32'd0);
      chk("perr_b",  {31'd0, perr_b},  32'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
    addr = a; din = d; be = m; we = 1'b1; re = 1'b0;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    addr = a; we = 1'b0; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_a && n < 100) begin
      addr = 4'd5; din = 16'hFFFF; be = '1;
      we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    int n;
    int vcnt;
    arstn = 1'b0; addr = '0; din = '0; be = '0; we = 1'b0; re = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  {31'd0, busy_a},  32'd1);
    chk("reset_valid", {31'd0, valid_b}, 32'd0);
    chk("reset_dout",  {16'd0, dout_b},  32'd0);
    #2 arstn = 1'b1;
    @(negedge clk);
    n = 1;
    begin
      int m;
      count_busy(m);
      n = n + m;
    end
    chk("clear_len", n, 32'd16);

    // Restart the clear sequence partway through
    repeat (2) @(negedge clk);
    #2 arstn = 1'b0;
    @(negedge clk);
    #2 arstn = 1'b1;
    @(negedge clk);
    repeat (6) begin
      addr = 4'd5; din = 16'hFFFF; be = '1; we = 1'b1; re = 1'b1;
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0;
    #2 arstn = 1'b0;
    @(negedge clk);
    chk("midclear_busy", {31'd0, busy_b}, 32'd1);
    #2 arstn = 1'b1;
    @(negedge clk);
    count_busy(n);
    chk("restart_len", n + 1, 32'd16);
    chk("busy_b_done", {31'd0, busy_b}, 32'd0);

    // Sweep all words after clear
    vcnt = 0;
    for (int a = 0; a < DEPTH; a++) begin
      addr = AW'(a); re = 1'b1;
      @(negedge clk);
      if (valid_a) vcnt++;
    end
    re = 1'b0;
    repeat (2) @(negedge clk);
    chk("sweep_valids", vcnt, 32'd16);
    chk("sweep_dout_a", {16'd0, dout_a}, 32'd0);
    chk("sweep_dout_b", {16'd0, dout_b}, 32'd0);

    // Byte-lane writes
    wr(4'd3, 16'hA5C3, 2'b11);
    wr(4'd3, 16'h00FF, 2'b01);
    rd(4'd3);
    chk("lane_a",  {16'd0, dout_a}, 32'hA5FF);
    @(negedge clk);
    chk("lane_b",  {16'd0, dout_b}, 32'hA5FF);
    chk("hold_a",  {16'd0, dout_a}, 32'hA5FF);
    wr(4'd3, 16'h1111, 2'b00);
    rd(4'd3);
    @(negedge clk);
    chk("be0_b",   {16'd0, dout_b}, 32'hA5FF);

    // Same-address read and write
    wr(4'd7, 16'h1234, 2'b11);
    addr = 4'd7; din = 16'hABCD; be = 2'b10; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    chk("rdw_first_a", {16'd0, dout_a}, 32'h1234);
    @(negedge clk);
    chk("rdw_wfirst_b", {16'd0, dout_b}, 32'hAB34);
    rd(4'd7);
    chk("rdw_after_a", {16'd0, dout_a}, 32'hAB34);
    @(negedge clk);
    chk("rdw_after_b", {16'd0, dout_b}, 32'hAB34);

    // Back-to-back reads through the 2-cycle pipeline
    wr(4'd1, 16'h0011, 2'b11);
    wr(4'd2, 16'h0022, 2'b11);
    wr(4'd3, 16'h0033, 2'b11);
    addr = 4'd1; re = 1'b1;
    @(negedge clk);
    addr = 4'd2;
    @(negedge clk);
    chk("b2b_v1", {31'd0, valid_b}, 32'd1);
    chk("b2b_d1", {16'd0, dout_b}, 32'h0011);
    addr = 4'd3;
    @(negedge clk);
    chk("b2b_d2", {16'd0, dout_b}, 32'h0022);
    re = 1'b0;
    @(negedge clk);
    chk("b2b_v3", {31'd0, valid_b}, 32'd1);
    chk("b2b_d3", {16'd0, dout_b}, 32'h0033);
    @(negedge clk);
    chk("b2b_drop_v", {31'd0, valid_b}, 32'd0);
    chk("b2b_hold_b", {16'd0, dout_b}, 32'h0033);
    chk("b2b_hold_a", {16'd0, dout_a}, 32'h0033);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      addr = AW'($urandom_range(0, DEPTH-1));
      din  = DW'($urandom);
      be   = NB'($urandom);
      we   = 1'($urandom_range(0, 1));
      re   = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0;
    repeat (3) @(negedge clk);

`ifdef SPRAM_BE_PARITY_EN
    wr(4'd6, 16'h5A3C, 2'b11);
    rd(4'd6);
    @(negedge clk);
    wr(4'd5, 16'h3C5A, 2'b11);
    model_on = 1'b0;
    u_a.u_core.mem[5][0][0] = ~u_a.u_core.mem[5][0][0];
    u_b.u_core.mem[5][0][0] = ~u_b.u_core.mem[5][0][0];
    rd(4'd5);
    chk("perr_flip_a", {31'd0, perr_a & valid_a}, 32'd1);
    @(negedge clk);
    chk("perr_flip_b", {31'd0, perr_b & valid_b}, 32'd1);
    rd(4'd6);
    chk("perr_clean_a", {31'd0, perr_a}, 32'd0);
    @(negedge clk);
    chk("perr_clean_b", {31'd0, perr_b}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spram_be.md
Name: spram_be

Overview:
- Parametrised successor to the generic single-port synchronous RAM.
- Adds per-byte write enables, selectable read latency (1 or 2), selectable read-during-write ordering, a read-valid strobe, and a post-reset hardware clear sequencer with a busy flag.
- Used as data/stack/DMA-buffer RAM behind spif and the CPU data path. Holds dout when not reading, so hold-off and DMA keep working.

Parameters:
- ADDR_WIDTH, 10: address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16: word width; must be a multiple of 8. NB = DATA_WIDTH/8 byte lanes.
- READ_LAT, 1: read latency in cycles, 1 or 2. 2 adds an output register stage.
- RDW_MODE, 0: read-during-write, same address. 0 = read-first (old word); 1 = write-first (merged new word).
- CLEAR_ON_RESET, 1: 1 = zero-fill all words after reset; 0 = no clear, busy never asserts.

Ports:
- clk  in  1  clock, all state on rising edge
- arstn  in  1  asynchronous active-low reset
- addr  in  ADDR_WIDTH  word address
- din  in  DATA_WIDTH  write data
- be  in  NB  byte-lane write enables, bit i covers din[8i+7:8i]
- we  in  1  write request
- re  in  1  read request
- dout  out  DATA_WIDTH  read data, held between reads
- valid  out  1  one-cycle strobe, dout updated this cycle
- busy  out  1  clear sequence running, requests ignored

Behaviour:
- Reset: arstn low asynchronously sets dout=0, valid=0, clear counter=0, and the stage-2 register (READ_LAT=2) to 0.
  - busy=1 if CLEAR_ON_RESET=1, else 0.
  - Array contents are not reset by arstn.
- FSM states are CLEAR and IDLE. Reset state is CLEAR if CLEAR_ON_RESET, else IDLE.
  - CLEAR: each cycle writes all-zero to mem[cnt], then cnt++. After writing the last address (2**ADDR_WIDTH-1), go to IDLE on the next edge and drop busy that edge.
  - Clear takes exactly 2**ADDR_WIDTH cycles after arstn deasserts.
  - arstn asserted mid-clear restarts the sequence at address 0.
- While busy=1: we/re are ignored, dout holds, valid=0.
- Write (IDLE, we=1): for each lane i with be[i]=1, mem[addr] lane i <= din lane i. Lanes with be[i]=0 are unchanged. we=1 with be=0 is a no-op.
- Read (IDLE, re=1):
  - READ_LAT=1: dout = mem[addr] at the next edge, valid=1 that cycle.
  - READ_LAT=2: data passes through one extra register. dout and valid appear 2 edges after the request. The pipeline accepts a read every cycle.
- re=0: dout holds its last value and valid=0. This hold is mandatory, not optional.
- Simultaneous we and re on the same address:
  - RDW_MODE=0: dout = old word.
  - RDW_MODE=1: dout = per-lane mux of din (be=1) and old word (be=0).
  - The write always completes.
- Addresses are a full power of two, so there is no out-of-range case.

Optional Feature:
- Macro: SPRAM_BE_PARITY_EN.
- Defined:
  - The array stores one even-parity bit per byte lane, computed from din at write time; clear writes parity 0.
  - Extra output perr (1 bit) is aligned with valid. It is 1 if any lane's recomputed parity mismatches the stored bit.
  - Reads merged with din under RDW_MODE=1 use the parity of the merged value, so perr=0 for those.
  - perr resets to 0.
- Undefined: no parity storage, no perr port, array width = DATA_WIDTH.

Decomposition:
- Package spram_pkg:
  - state enum {ST_CLEAR, ST_IDLE}
  - constants RDW_READ_FIRST=0, RDW_WRITE_FIRST=1
  - function byte_merge(old, new, be)
  - function byte_parity(word)
- One sub-module, spram_be_core: the inferred byte-lane array, 1-cycle registered read, RDW ordering. It has no reset.
- The top adds the clear FSM, address/data muxing, latency stage, valid and parity.

Test Plan:
1. arstn pulse, ADDR_WIDTH=4 -> busy=1 for exactly 16 cycles; reading all 16 addresses afterwards gives 0x0000. Re-assert arstn at cycle 7 -> sequence restarts, busy lasts 16 more cycles.
2. Write 0xA5C3 to addr 3 with be=11, then 0x00FF with be=01 -> read gives 0xA5FF. Write with be=00 -> data unchanged.
3. Same-address read+write, old=0x1234, din=0xABCD, be=10 -> RDW_MODE=0 gives dout=0x1234; RDW_MODE=1 gives 0xAB34. A following read gives 0xAB34 in both modes.
4. READ_LAT=2, back-to-back reads of addr 1,2,3 holding 0x0011, 0x0022, 0x0033 -> valid high on cycles 2,3,4 with matching dout. dout holds 0x0033 after re drops.
5. re/we asserted during busy -> no write occurs (word reads 0 after clear), valid stays 0.
6. SPRAM_BE_PARITY_EN: force a bit flip in the stored word at addr 5 -> read gives perr=1 with valid. Clean reads give perr=0.
